// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - UART transmit serializer with RTS/CTS line request and programmable baud divider
// Parity bit support is built only when UART_TX_PARITY_EN is defined.
module uart_tx_serializer #(
    parameter int DATA_BITS = 8,
    parameter int DIV_W     = 16
) (
    input  logic                 tck,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 tx_enable,
    output logic                 tx_rts_n,
    input  logic                 tx_cts_n,
    output logic                 txd,
    output logic                 busy,
    input  logic [DIV_W-1:0]     cfg_div,
    input  logic                 cfg_parity_en,
    input  logic                 cfg_parity_odd,
    input  logic                 cfg_two_stop
);

    localparam int CNT_W = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REQ    = 3'd1,
        S_START  = 3'd2,
        S_DATA   = 3'd3,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd4,
`endif
        S_STOP   = 3'd5
    } state_t;

    state_t                 state_q, state_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [DIV_W-1:0]       div_q, div_d;
    logic [DIV_W-1:0]       baud_q, baud_d;
    logic [CNT_W-1:0]       bit_q, bit_d;
    logic                   two_stop_q, two_stop_d;
    logic                   txd_q, txd_d;
    logic                   rts_n_q, rts_n_d;
    logic                   busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
    logic                   parity_en_q, parity_en_d;
    logic                   parity_q, parity_d;
`else
    logic                   unused_cfg;
    assign unused_cfg = cfg_parity_en ^ cfg_parity_odd;
`endif

    logic accept;
    logic bit_end;
    logic last_data;
    logic last_stop;

    assign in_ready  = (state_q == S_IDLE) && tx_enable;
    assign accept    = in_valid && in_ready;
    assign bit_end   = (baud_q == '0);
    assign last_data = (bit_q == CNT_W'(DATA_BITS - 1));
    assign last_stop = (bit_q == (two_stop_q ? CNT_W'(1) : CNT_W'(0)));

    assign txd      = txd_q;
    assign tx_rts_n = rts_n_q;
    assign busy     = busy_q;

    always_ff @(posedge tck or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_REQ;
            S_REQ:   if (tx_enable && !tx_cts_n) state_d = S_START;
            S_START: if (bit_end) state_d = S_DATA;
            S_DATA: begin
                if (bit_end && last_data) begin
`ifdef UART_TX_PARITY_EN
                    state_d = parity_en_q ? S_PARITY : S_STOP;
`else
                    state_d = S_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: if (bit_end) state_d = S_STOP;
`endif
            S_STOP:  if (bit_end && last_stop) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Frame parameters are captured at acceptance so later cfg_* changes cannot disturb the frame.
    always_comb begin
        shift_d    = shift_q;
        div_d      = div_q;
        two_stop_d = two_stop_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
`ifdef UART_TX_PARITY_EN
        parity_en_d = parity_en_q;
        parity_d    = parity_q;
`endif
        if (state_q == S_IDLE) begin
            baud_d = '0;
            bit_d  = '0;
            if (accept) begin
                shift_d    = in_data;
                div_d      = cfg_div;
                two_stop_d = cfg_two_stop;
`ifdef UART_TX_PARITY_EN
                parity_en_d = cfg_parity_en;
                parity_d    = (^in_data) ^ cfg_parity_odd;
`endif
            end
        end else if (state_q == S_REQ) begin
            baud_d = div_q;
            bit_d  = '0;
        end else if (bit_end) begin
            baud_d = div_q;
            bit_d  = '0;
            if (state_q == S_DATA && !last_data) begin
                bit_d   = bit_q + CNT_W'(1);
                shift_d = shift_q >> 1;
            end else if (state_q == S_STOP && !last_stop) begin
                bit_d = bit_q + CNT_W'(1);
            end
        end else begin
            baud_d = baud_q - DIV_W'(1);
        end
        if (state_d == S_IDLE) begin
            baud_d = '0;
        end
    end

    // Outputs are decoded from the next state so the pins change on the same edge as the state.
    always_comb begin
        txd_d   = 1'b1;
        rts_n_d = 1'b1;
        busy_d  = 1'b1;
        case (state_d)
            S_IDLE:  busy_d = 1'b0;
            S_REQ:   rts_n_d = !tx_enable;
            S_START: begin
                txd_d   = 1'b0;
                rts_n_d = 1'b0;
            end
            S_DATA: begin
                txd_d   = shift_d[0];
                rts_n_d = 1'b0;
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                txd_d   = parity_q;
                rts_n_d = 1'b0;
            end
`endif
            S_STOP:  rts_n_d = 1'b0;
            default: busy_d = 1'b0;
        endcase
    end

    always_ff @(posedge tck or posedge rst) begin
        if (rst) begin
            shift_q    <= '0;
            div_q      <= '0;
            baud_q     <= '0;
            bit_q      <= '0;
            two_stop_q <= 1'b0;
            txd_q      <= 1'b1;
            rts_n_q    <= 1'b1;
            busy_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_en_q <= 1'b0;
            parity_q    <= 1'b0;
`endif
        end else begin
            shift_q    <= shift_d;
            div_q      <= div_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            two_stop_q <= two_stop_d;
            txd_q      <= txd_d;
            rts_n_q    <= rts_n_d;
            busy_q     <= busy_d;
`ifdef UART_TX_PARITY_EN
            parity_en_q <= parity_en_d;
            parity_q    <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb/tb_uart_tx_serializer.sv - self-checking bench for uart_tx_serializer
`timescale 1ns/1ps
module tb_uart_tx_serializer;

    localparam int DATA_BITS = 8;
    localparam int DIV_W     = 16;
`ifdef UART_TX_PARITY_EN
    localparam bit PARITY_BUILT = 1'b1;
`else
    localparam bit PARITY_BUILT = 1'b0;
`endif

    logic                 tck = 1'b0;
    logic                 rst;
    logic [DATA_BITS-1:0] in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic                 tx_enable;
    logic                 tx_rts_n;
    logic                 tx_cts_n;
    logic                 txd;
    logic                 busy;
    logic [DIV_W-1:0]     cfg_div;
    logic                 cfg_parity_en;
    logic                 cfg_parity_odd;
    logic                 cfg_two_stop;

    int checks = 0;
    int errors = 0;
    logic exp_q[$];

    uart_tx_serializer #(.DATA_BITS(DATA_BITS), .DIV_W(DIV_W)) dut (
        .tck(tck), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .tx_enable(tx_enable), .tx_rts_n(tx_rts_n), .tx_cts_n(tx_cts_n), .txd(txd), .busy(busy),
        .cfg_div(cfg_div), .cfg_parity_en(cfg_parity_en), .cfg_parity_odd(cfg_parity_odd),
        .cfg_two_stop(cfg_two_stop)
    );

    always #5 tck = ~tck;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected line waveform, one entry per clock cycle of the frame.
    task automatic model_frame(input logic [7:0] data, input int div, input logic pen,
                               input logic podd, input logic two);
        logic bits[$];
        int   ones;
        bits = {};
        ones = 0;
        bits.push_back(1'b0);
        for (int i = 0; i < DATA_BITS; i++) begin
            bits.push_back(data[i]);
            ones += int'(data[i]);
        end
        if (pen && PARITY_BUILT) bits.push_back(logic'(ones % 2) ^ podd);
        bits.push_back(1'b1);
        if (two) bits.push_back(1'b1);
        exp_q = {};
        foreach (bits[b]) repeat (div + 1) exp_q.push_back(bits[b]);
    endtask

    task automatic play_frame(input bit disturb);
        int n;
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge tck);
            check($sformatf("txd[%0d]", i), txd, exp_q[i]);
            check($sformatf("frame_rts[%0d]", i), tx_rts_n, 0);
            check($sformatf("frame_busy[%0d]", i), busy, 1);
            if (disturb && i == n / 2) begin
                tx_cts_n     = 1'b1;
                cfg_div      = DIV_W'($urandom_range(4, 15));
                cfg_two_stop = ~cfg_two_stop;
                in_data      = DATA_BITS'($urandom);
                #1 check("frame_in_ready", in_ready, 0);
            end
        end
        @(negedge tck);
        check("end_rts", tx_rts_n, 1);
        check("end_busy", busy, 0);
        check("end_txd", txd, 1);
        tx_cts_n = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] data, input int div, input logic pen,
                             input logic podd, input logic two, input int cts_delay,
                             input bit disturb);
        in_data        = data;
        cfg_div        = DIV_W'(div);
        cfg_parity_en  = pen;
        cfg_parity_odd = podd;
        cfg_two_stop   = two;
        in_valid       = 1'b1;
        tx_cts_n       = (cts_delay > 0);
        #1 check("in_ready_idle", in_ready, 1);
        model_frame(data, div, pen, podd, two);
        @(negedge tck);
        in_valid = 1'b0;
        in_data  = DATA_BITS'($urandom);
        for (int i = 0; i < cts_delay; i++) begin
            check("wait_txd", txd, 1);
            check("wait_rts", tx_rts_n, 0);
            check("wait_busy", busy, 1);
            @(negedge tck);
        end
        check("req_rts", tx_rts_n, 0);
        tx_cts_n = 1'b0;
        play_frame(disturb);
    endtask

    initial begin
        rst            = 1'b1;
        in_data        = '0;
        in_valid       = 1'b0;
        tx_enable      = 1'b1;
        tx_cts_n       = 1'b0;
        cfg_div        = '0;
        cfg_parity_en  = 1'b0;
        cfg_parity_odd = 1'b0;
        cfg_two_stop   = 1'b0;
        repeat (2) @(negedge tck);
        check("rst_txd", txd, 1);
        check("rst_rts", tx_rts_n, 1);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);
        rst = 1'b0;
        @(negedge tck);

        // 8N1, divisor 3, 0xA5
        send_word(8'hA5, 3, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        // parity even / odd on 0x07
        send_word(8'h07, 0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        send_word(8'h07, 0, 1'b1, 1'b1, 1'b0, 0, 1'b0);
        // delayed grant
        send_word(8'hC3, 1, 1'b0, 1'b0, 1'b1, 10, 1'b0);
        // CTS drop and config changes mid-frame
        send_word(8'h3C, 2, 1'b1, 1'b0, 1'b0, 0, 1'b1);

        // transmit disabled in IDLE: nothing is accepted
        tx_enable = 1'b0;
        in_data   = 8'h99;
        in_valid  = 1'b1;
        #1 check("dis_in_ready", in_ready, 0);
        repeat (3) @(negedge tck);
        check("dis_busy", busy, 0);
        check("dis_rts", tx_rts_n, 1);
        in_valid  = 1'b0;
        tx_enable = 1'b1;

        // enable dropped during REQ; word held and sent after re-enable
        in_data        = 8'h5A;
        cfg_div        = DIV_W'(1);
        cfg_parity_en  = 1'b0;
        cfg_two_stop   = 1'b0;
        tx_cts_n       = 1'b1;
        in_valid       = 1'b1;
        model_frame(8'h5A, 1, 1'b0, 1'b0, 1'b0);
        @(negedge tck);
        in_valid = 1'b0;
        in_data  = 8'hFF;
        check("req_rts_on", tx_rts_n, 0);
        tx_enable = 1'b0;
        @(negedge tck);
        check("req_dis_rts", tx_rts_n, 1);
        check("req_dis_busy", busy, 1);
        tx_cts_n = 1'b0;
        @(negedge tck);
        check("req_dis_txd", txd, 1);
        check("req_dis_rts2", tx_rts_n, 1);
        tx_enable = 1'b1;
        tx_cts_n  = 1'b1;
        @(negedge tck);
        check("req_reen_rts", tx_rts_n, 0);
        check("req_reen_txd", txd, 1);
        tx_cts_n = 1'b0;
        play_frame(1'b0);

        // async reset in the middle of the data bits
        in_data  = 8'h00;
        cfg_div  = DIV_W'(2);
        in_valid = 1'b1;
        @(negedge tck);
        in_valid = 1'b0;
        repeat (8) @(negedge tck);
        check("pre_rst_txd", txd, 0);
        #1 rst = 1'b1;
        #1;
        check("arst_txd", txd, 1);
        check("arst_rts", tx_rts_n, 1);
        check("arst_busy", busy, 0);
        @(negedge tck);
        rst = 1'b0;
        @(negedge tck);
        send_word(8'h81, 2, 1'b0, 1'b0, 1'b1, 0, 1'b0);

        // randomized frames
        for (int r = 0; r < 12; r++) begin
            send_word(8'($urandom), $urandom_range(0, 3), 1'($urandom), 1'($urandom),
                      1'($urandom), $urandom_range(0, 3), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
